cnna_mul_pipe: RTL and testbench
================================

Name: cnna_mul_pipe

Overview:
- Parametrised, pipelined integer multiplier for the cnna datapath.
- Successor to the fixed-width single-cycle HLS multipliers (13ns x 5ns -> 18, for example).
- Adds configurable operand and result widths, per-operand signedness, NUM_STAGE register depth, a valid/ready handshake with backpressure, and a sideband tag carried with each product.
- Sits between the feature/weight fetch logic and the accumulator tree.

Parameters:
- A_W, 13: width of operand a.
- B_W, 5: width of operand b.
- DOUT_W, 18: result width. Legal range 2..A_W+B_W.
- A_SIGNED, 0: 1 means a is two's complement.
- B_SIGNED, 0: 1 means b is two's complement.
- NUM_STAGE, 3: pipeline register stages, input to output. Legal range 1..8.
- TAG_W, 4: sideband tag width. Legal minimum 1.

Ports:
- ap_clk  in  1  single clock; all state updates on the rising edge.
- ap_rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  din0/din1/in_tag are valid this cycle.
- in_ready  out  1  block accepts the input this cycle.
- din0  in  A_W  operand a.
- din1  in  B_W  operand b.
- in_tag  in  TAG_W  sideband, carried unchanged alongside the operands.
- out_valid  out  1  dout/out_tag are valid.
- out_ready  in  1  downstream accepts the output this cycle.
- dout  out  DOUT_W  product.
- out_tag  out  TAG_W  tag of the input that produced dout.
- ovf  out  1  full product did not fit in DOUT_W; qualified by out_valid.

Behaviour:
- Transfers: input transfer = in_valid & in_ready; output transfer = out_valid & out_ready.
- Global enable: ce = ~out_valid | out_ready. in_ready = ce. This is combinational and has no dependency on in_valid.
- Pipeline advance: when ce=1, every stage advances by one. Stage 0 captures the operands, tag, and valid = in_valid. When ce=0, all stage registers hold, including the valid bits.
- Latency: exactly NUM_STAGE cycles from input transfer to out_valid, with no stall in between. Throughput is 1 per cycle while out_ready=1.
- Bubbles: invalid slots travel through the pipeline like data. They are not collapsed, so a bubble ahead of the output does not stall the pipe.
- Extension: each operand is sign-extended if its *_SIGNED=1, otherwise zero-extended, to A_W+B_W bits. The full product P is formed at A_W+B_W bits. The multiply sits in stage 0 and the remaining stages are retiming registers; the multiply may be split across stages provided the latency is unchanged.
- Result without saturation: dout = P[DOUT_W-1:0] (wrap).
- ovf: set when P is not representable in DOUT_W bits. Signed if either operand is signed, unsigned otherwise.
- Output stability: while out_valid=1 and out_ready=0, dout, out_tag and ovf hold stable.
- Reset (asynchronous, ap_rst_n=0):
  - All valid bits clear immediately, so out_valid=0.
  - dout=0, out_tag=0, ovf=0; all data registers clear.
  - in_ready=1 during and after reset.
  - In-flight data is discarded, including on reset mid-stall.
- Reset release is synchronous to ap_clk; the first input transfer may occur on the first edge after release.
- Simultaneous events: an output transfer and an input transfer in the same cycle while the pipeline is full are legal, and no data is lost.
- Boundary, mixed signedness: with A_SIGNED=1 and B_SIGNED=0, b is treated as non-negative.
- Boundary, full width: with DOUT_W=A_W+B_W, ovf is constant 0.

Optional Feature:
- Macro: CNNA_MUL_SAT_EN.
- Defined: when ovf=1, dout saturates instead of wrapping.
  - Unsigned result: clamps to all-ones.
  - Signed result: clamps to the most positive value, 2^(DOUT_W-1)-1, or the most negative value, -2^(DOUT_W-1), according to the sign of P.
  - ovf is still reported.
- Not defined: dout wraps as specified under Behaviour. No saturation logic is synthesised.

Test Plan:
- Defaults, streaming: din0=8191, din1=31, tag=5, out_ready=1 -> 3 cycles later dout=253921, out_tag=5, ovf=0. A back-to-back stream of 10 random pairs gives 10 results in consecutive cycles, in order.
- Backpressure: fill the pipe, then out_ready=0 for 4 cycles -> in_ready=0, dout and out_tag held. Release -> all results emerge in order with none duplicated or dropped.
- Signed, A_SIGNED=1, B_SIGNED=1, A_W=8, B_W=8, DOUT_W=16: a=-128, b=-128 -> dout=16384; a=-1, b=127 -> dout=-127 (0xFF81); ovf=0.
- Overflow, DOUT_W=16 unsigned: a=8191, b=31 ->
  - Without the macro: dout=0xDFE1, ovf=1.
  - With CNNA_MUL_SAT_EN: dout=0xFFFF, ovf=1.
- Reset mid-operation: 2 results in flight with out_ready=0, assert ap_rst_n=0 between edges -> out_valid=0 and dout=0 immediately. After release a new input gives exactly one output, 3 cycles later.
- NUM_STAGE=1 with bubbles: alternating in_valid=1/0 -> out_valid follows in_valid delayed by 1 cycle; in_ready stays 1 throughout.

Source files
------------

// File: rtl/cnna_mul_pipe.sv
// -----------------------------------------------------------------------------
// cnna_mul_pipe
// Parametrised, pipelined integer multiplier for the cnna datapath. It sits
// between the feature/weight fetch logic and the accumulator tree.
//
// The operands are extended to A_W+B_W bits and multiplied into the full
// product P. The result is then formed as a DOUT_W-bit value, and the overflow
// flag is computed. All of this happens in front of stage 0. The remaining
// NUM_STAGE-1 stages are retiming registers only. A single global enable stalls
// the whole pipe when the output is held. Bubbles travel through the pipe like
// data.
//
// Parameters:
//   A_W, B_W   operand widths
//   DOUT_W     result width (2 .. A_W+B_W)
//   A_SIGNED   1 -> operand a is two's complement
//   B_SIGNED   1 -> operand b is two's complement
//   NUM_STAGE  register stages from input to output (1 .. 8)
//   TAG_W      sideband tag width (>= 1)
//
// Ports:
//   ap_clk, ap_rst_n   clock, asynchronous active-low reset
//   in_valid/in_ready  input handshake; in_ready = ~out_valid | out_ready
//   din0, din1, in_tag operand a, operand b, sideband tag
//   out_valid/out_ready output handshake
//   dout, out_tag, ovf product, its tag, product did not fit in DOUT_W
//
// Build option:
//   CNNA_MUL_SAT_EN  when defined, dout saturates on overflow instead of
//                    wrapping. The ovf flag is still reported.
// -----------------------------------------------------------------------------
module cnna_mul_pipe #(
   parameter int A_W       = 13,
   parameter int B_W       = 5,
   parameter int DOUT_W    = 18,
   parameter int A_SIGNED  = 0,
   parameter int B_SIGNED  = 0,
   parameter int NUM_STAGE = 3,
   parameter int TAG_W     = 4
) (
   input  logic              ap_clk,
   input  logic              ap_rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [A_W-1:0]    din0,
   input  logic [B_W-1:0]    din1,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DOUT_W-1:0] dout,
   output logic [TAG_W-1:0]  out_tag,
   output logic              ovf
);

   localparam int P_W        = A_W + B_W;
   localparam bit RES_SIGNED = (A_SIGNED != 0) || (B_SIGNED != 0);

   logic              w_a_sx;
   logic              w_b_sx;
   logic [P_W-1:0]    w_a_ext;
   logic [P_W-1:0]    w_b_ext;
   logic [P_W-1:0]    w_prod;
   logic              w_ovf;
   logic [DOUT_W-1:0] w_dout;
   logic              w_ce;

   logic              r_vld  [NUM_STAGE];
   logic [DOUT_W-1:0] r_dout [NUM_STAGE];
   logic [TAG_W-1:0]  r_tag  [NUM_STAGE];
   logic              r_ovf  [NUM_STAGE];

   // A held output stalls the whole pipe. Otherwise every stage moves,
   // including bubbles.
   assign w_ce     = ~r_vld[NUM_STAGE-1] | out_ready;
   assign in_ready = w_ce;

   // Operand extension. An unsigned operand always contributes a non-negative
   // value.
   assign w_a_sx  = (A_SIGNED != 0) ? din0[A_W-1] : 1'b0;
   assign w_b_sx  = (B_SIGNED != 0) ? din1[B_W-1] : 1'b0;
   assign w_a_ext = {{B_W{w_a_sx}}, din0};
   assign w_b_ext = {{A_W{w_b_sx}}, din1};

   // The low P_W bits of the product of the two extended operands form the
   // exact two's-complement product. The full product always fits in P_W bits.
   assign w_prod  = w_a_ext * w_b_ext;

   generate
      if (RES_SIGNED) begin : g_ovf_signed
         // The product fits only if every bit from DOUT_W-1 upward equals the
         // sign bit.
         assign w_ovf = ~((&w_prod[P_W-1:DOUT_W-1]) | ~(|w_prod[P_W-1:DOUT_W-1]));
      end else if (DOUT_W < P_W) begin : g_ovf_unsigned
         assign w_ovf = |w_prod[P_W-1:DOUT_W];
      end else begin : g_ovf_none
         // An unsigned product at full width can never overflow.
         assign w_ovf = 1'b0;
      end
   endgenerate

`ifdef CNNA_MUL_SAT_EN
   // Clamp an unrepresentable product to the nearest limit of the result range.
   always_comb begin
      w_dout = w_prod[DOUT_W-1:0];
      if (w_ovf) begin
         if (RES_SIGNED) begin
            if (w_prod[P_W-1]) begin
               w_dout = {1'b1, {(DOUT_W-1){1'b0}}};
            end else begin
               w_dout = {1'b0, {(DOUT_W-1){1'b1}}};
            end
         end else begin
            w_dout = {DOUT_W{1'b1}};
         end
      end else begin
         w_dout = w_prod[DOUT_W-1:0];
      end
   end
`else
   assign w_dout = w_prod[DOUT_W-1:0];
`endif

   // Pipeline registers. Stage 0 captures the result, and the later stages
   // shift when the pipe is enabled.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         for (int i = 0; i < NUM_STAGE; i++) begin
            r_vld[i]  <= 1'b0;
            r_dout[i] <= {DOUT_W{1'b0}};
            r_tag[i]  <= {TAG_W{1'b0}};
            r_ovf[i]  <= 1'b0;
         end
      end else if (w_ce) begin
         r_vld[0]  <= in_valid;
         r_dout[0] <= w_dout;
         r_tag[0]  <= in_tag;
         r_ovf[0]  <= w_ovf;
         for (int i = 1; i < NUM_STAGE; i++) begin
            r_vld[i]  <= r_vld[i-1];
            r_dout[i] <= r_dout[i-1];
            r_tag[i]  <= r_tag[i-1];
            r_ovf[i]  <= r_ovf[i-1];
         end
      end
   end

   assign out_valid = r_vld[NUM_STAGE-1];
   assign dout      = r_dout[NUM_STAGE-1];
   assign out_tag   = r_tag[NUM_STAGE-1];
   assign ovf       = r_ovf[NUM_STAGE-1];

endmodule

// File: tb/tb_cnna_mul_pipe.sv
// -----------------------------------------------------------------------------
// tb_cnna_mul_pipe
// This bench drives five multiplier configurations from one clock:
//   0: defaults (13x5 -> 18 unsigned, 3 stages)
//   1: 8x8 -> 16, both operands signed
//   2: 13x5 -> 16 unsigned (overflow / saturation)
//   3: defaults with NUM_STAGE = 1
//   4: 8x8 -> 16, a signed and b unsigned
// A reference model computes each product from plain integer arithmetic. It
// tracks every accepted item by the number of pipeline advances it still needs.
// Once per cycle, all outputs are compared against this model. Directed literal
// checks pin the model's results.
// -----------------------------------------------------------------------------
module tb_cnna_mul_pipe;

   typedef struct {
      longint dout;
      longint tag;
      bit     ovf;
      int     rem;
   } exp_t;

   int AW [5] = '{13, 8, 13, 13, 8};
   int BW [5] = '{5, 8, 5, 5, 8};
   int DW [5] = '{18, 16, 16, 18, 16};
   int AS [5] = '{0, 1, 0, 0, 1};
   int BS [5] = '{0, 1, 0, 0, 0};
   int NS [5] = '{3, 3, 3, 1, 3};

   logic clk = 1'b0;
   logic rst_n = 1'b1;

   logic        in_v   [5];
   logic        out_r  [5];
   logic [15:0] a_d    [5];
   logic [15:0] b_d    [5];
   logic [3:0]  t_d    [5];
   logic        o_irdy [5];
   logic        o_vld  [5];
   logic        o_ovf  [5];
   logic [3:0]  o_tag  [5];
   logic [63:0] o_dout [5];

   logic [17:0] d0;
   logic [15:0] d1;
   logic [15:0] d2;
   logic [17:0] d3;
   logic [15:0] d4;

   exp_t q [5][$];
   int   n_chk = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   assign o_dout[0] = {46'd0, d0};
   assign o_dout[1] = {48'd0, d1};
   assign o_dout[2] = {48'd0, d2};
   assign o_dout[3] = {46'd0, d3};
   assign o_dout[4] = {48'd0, d4};

   cnna_mul_pipe u_dut0 (.ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_v[0]), .in_ready(o_irdy[0]),
      .din0(a_d[0][12:0]), .din1(b_d[0][4:0]), .in_tag(t_d[0]), .out_valid(o_vld[0]),
      .out_ready(out_r[0]), .dout(d0), .out_tag(o_tag[0]), .ovf(o_ovf[0]));

   cnna_mul_pipe #(.A_W(8), .B_W(8), .DOUT_W(16), .A_SIGNED(1), .B_SIGNED(1)) u_dut1 (
      .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_v[1]), .in_ready(o_irdy[1]),
      .din0(a_d[1][7:0]), .din1(b_d[1][7:0]), .in_tag(t_d[1]), .out_valid(o_vld[1]),
      .out_ready(out_r[1]), .dout(d1), .out_tag(o_tag[1]), .ovf(o_ovf[1]));

   cnna_mul_pipe #(.DOUT_W(16)) u_dut2 (.ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_v[2]),
      .in_ready(o_irdy[2]), .din0(a_d[2][12:0]), .din1(b_d[2][4:0]), .in_tag(t_d[2]),
      .out_valid(o_vld[2]), .out_ready(out_r[2]), .dout(d2), .out_tag(o_tag[2]), .ovf(o_ovf[2]));

   cnna_mul_pipe #(.NUM_STAGE(1)) u_dut3 (.ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_v[3]),
      .in_ready(o_irdy[3]), .din0(a_d[3][12:0]), .din1(b_d[3][4:0]), .in_tag(t_d[3]),
      .out_valid(o_vld[3]), .out_ready(out_r[3]), .dout(d3), .out_tag(o_tag[3]), .ovf(o_ovf[3]));

   cnna_mul_pipe #(.A_W(8), .B_W(8), .DOUT_W(16), .A_SIGNED(1), .B_SIGNED(0)) u_dut4 (
      .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_v[4]), .in_ready(o_irdy[4]),
      .din0(a_d[4][7:0]), .din1(b_d[4][7:0]), .in_tag(t_d[4]), .out_valid(o_vld[4]),
      .out_ready(out_r[4]), .dout(d4), .out_tag(o_tag[4]), .ovf(o_ovf[4]));

   task automatic chk(input string name, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
      end
   endtask

   // Reference product: interpret operands by signedness, multiply, range-check.
   function automatic exp_t model(input int k, input logic [15:0] a, input logic [15:0] b,
                                  input logic [3:0] t);
      exp_t   e;
      longint one = 1;
      longint av  = longint'(a) & ((one << AW[k]) - 1);
      longint bv  = longint'(b) & ((one << BW[k]) - 1);
      longint p;
      longint lo;
      longint hi;
      longint r;
      if (AS[k] != 0 && av >= (one << (AW[k] - 1))) av = av - (one << AW[k]);
      if (BS[k] != 0 && bv >= (one << (BW[k] - 1))) bv = bv - (one << BW[k]);
      p = av * bv;
      if (AS[k] != 0 || BS[k] != 0) begin
         lo = -(one << (DW[k] - 1));
         hi = (one << (DW[k] - 1)) - 1;
      end else begin
         lo = 0;
         hi = (one << DW[k]) - 1;
      end
      e.ovf = (p < lo) || (p > hi);
      r = p;
`ifdef CNNA_MUL_SAT_EN
      if (e.ovf) r = (p < lo) ? lo : hi;
`endif
      e.dout = r & ((one << DW[k]) - 1);
      e.tag  = longint'(t);
      e.rem  = 0;
      return e;
   endfunction

   // Per-cycle compare of all outputs against the model, then advance the model
   // by what the coming clock edge will do.
   task automatic model_cycle();
      for (int k = 0; k < 5; k++) begin
         bit   ev;
         bit   ce;
         exp_t e;
         if (!rst_n) begin
            q[k].delete();
            chk($sformatf("rst_vld%0d", k), longint'(o_vld[k]), 0);
         end else begin
            ev = (q[k].size() != 0) && (q[k][0].rem == 0);
            chk($sformatf("out_valid%0d", k), longint'(o_vld[k]), longint'(ev));
            ce = !ev || out_r[k];
            chk($sformatf("in_ready%0d", k), longint'(o_irdy[k]), longint'(ce));
            if (ev && o_vld[k]) begin
               chk($sformatf("dout%0d", k), longint'(o_dout[k]), q[k][0].dout);
               chk($sformatf("out_tag%0d", k), longint'(o_tag[k]), q[k][0].tag);
               chk($sformatf("ovf%0d", k), longint'(o_ovf[k]), longint'(q[k][0].ovf));
            end
            if (ce) begin
               if (ev) void'(q[k].pop_front());
               for (int j = 0; j < q[k].size(); j++) begin
                  if (q[k][j].rem > 0) q[k][j].rem = q[k][j].rem - 1;
               end
               if (in_v[k]) begin
                  e = model(k, a_d[k], b_d[k], t_d[k]);
                  e.rem = NS[k] - 1;
                  q[k].push_back(e);
               end
            end
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      model_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int k, input int a, input int b, input int t);
      in_v[k] = 1'b1;
      a_d[k]  = 16'(a);
      b_d[k]  = 16'(b);
      t_d[k]  = 4'(t);
   endtask

   initial begin
      int     cnt;
      int     first;
      int     last;
      longint held_d;
      longint held_t;

      for (int k = 0; k < 5; k++) begin
         in_v[k]  = 1'b0;
         out_r[k] = 1'b1;
         a_d[k]   = 16'd0;
         b_d[k]   = 16'd0;
         t_d[k]   = 4'd0;
      end

      // Reset state
      #1 rst_n = 1'b0;
      #1;
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("reset_vld%0d", k), longint'(o_vld[k]), 0);
         chk($sformatf("reset_dout%0d", k), longint'(o_dout[k]), 0);
         chk($sformatf("reset_tag%0d", k), longint'(o_tag[k]), 0);
         chk($sformatf("reset_ovf%0d", k), longint'(o_ovf[k]), 0);
         chk($sformatf("reset_rdy%0d", k), longint'(o_irdy[k]), 1);
      end
      step();
      step();
      rst_n = 1'b1;
      step();

      // Single product with defaults
      drive(0, 8191, 31, 5);
      step();
      in_v[0] = 1'b0;
      step();
      chk("lat_early", longint'(o_vld[0]), 0);
      step();
      chk("lat_vld", longint'(o_vld[0]), 1);
      chk("lat_dout", longint'(o_dout[0]), 253921);
      chk("lat_tag", longint'(o_tag[0]), 5);
      chk("lat_ovf", longint'(o_ovf[0]), 0);
      step();

      // Back-to-back stream of 10 random pairs
      cnt = 0; first = -1; last = -1;
      for (int i = 0; i < 13; i++) begin
         if (i < 10) drive(0, int'($urandom_range(0, 8191)), int'($urandom_range(0, 31)), i);
         else in_v[0] = 1'b0;
         step();
         if (o_vld[0]) begin
            cnt++;
            if (first < 0) first = i;
            last = i;
         end
      end
      chk("stream_cnt", longint'(cnt), 10);
      chk("stream_first", longint'(first), 2);
      chk("stream_last", longint'(last), 11);

      // Backpressure: fill, stall 4 cycles while offering more input, release
      for (int i = 0; i < 3; i++) begin
         drive(0, 100 + i, 3 + i, 8 + i);
         step();
      end
      out_r[0] = 1'b0;
      drive(0, 200, 7, 12);
      held_d = longint'(o_dout[0]);
      held_t = longint'(o_tag[0]);
      chk("bp_first", held_d, 300);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("bp_rdy", longint'(o_irdy[0]), 0);
         chk("bp_vld", longint'(o_vld[0]), 1);
         chk("bp_dout_hold", longint'(o_dout[0]), held_d);
         chk("bp_tag_hold", longint'(o_tag[0]), held_t);
      end
      out_r[0] = 1'b1;
      step();
      drive(0, 300, 9, 13);
      step();
      in_v[0] = 1'b0;
      for (int i = 0; i < 6; i++) step();
      chk("bp_drained", longint'(q[0].size()), 0);

      // Signed operands
      drive(1, -128, -128, 1);
      step();
      drive(1, -1, 127, 2);
      step();
      in_v[1] = 1'b0;
      step();
      chk("s_vld", longint'(o_vld[1]), 1);
      chk("s_dout1", longint'(o_dout[1]), 16384);
      chk("s_tag1", longint'(o_tag[1]), 1);
      step();
      chk("s_dout2", longint'(o_dout[1]), 'hFF81);
      chk("s_ovf2", longint'(o_ovf[1]), 0);
      step();

      // Mixed signedness: b is treated as non-negative
      drive(4, -1, 255, 3);
      step();
      drive(4, -128, 255, 4);
      step();
      in_v[4] = 1'b0;
      step();
      chk("mix_dout", longint'(o_dout[4]), 'hFF01);
      chk("mix_ovf", longint'(o_ovf[4]), 0);
      step();
      step();

      // Overflow at DOUT_W=16
      drive(2, 8191, 31, 4);
      step();
      drive(2, 1000, 31, 5);
      step();
      in_v[2] = 1'b0;
      step();
      chk("ovf_flag", longint'(o_ovf[2]), 1);
`ifdef CNNA_MUL_SAT_EN
      chk("ovf_dout", longint'(o_dout[2]), 'hFFFF);
`else
      chk("ovf_dout", longint'(o_dout[2]), 'hDFE1);
`endif
      step();
      chk("nov_dout", longint'(o_dout[2]), 31000);
      chk("nov_flag", longint'(o_ovf[2]), 0);
      step();

      // Reset while two results are in flight and the output is stalled
      drive(0, 11, 2, 6);
      step();
      drive(0, 12, 3, 7);
      step();
      in_v[0] = 1'b0;
      out_r[0] = 1'b0;
      step();
      step();
      chk("mid_stall_vld", longint'(o_vld[0]), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_vld", longint'(o_vld[0]), 0);
      chk("mid_rst_dout", longint'(o_dout[0]), 0);
      chk("mid_rst_rdy", longint'(o_irdy[0]), 1);
      step();
      rst_n = 1'b1;
      out_r[0] = 1'b1;
      drive(0, 7, 7, 9);
      cnt = 0; first = -1;
      for (int i = 0; i < 6; i++) begin
         step();
         if (i == 0) in_v[0] = 1'b0;
         if (o_vld[0]) begin
            cnt++;
            if (first < 0) first = i;
         end
      end
      chk("post_rst_cnt", longint'(cnt), 1);
      chk("post_rst_lat", longint'(first), 2);

      // NUM_STAGE=1 with alternating bubbles
      for (int i = 0; i < 8; i++) begin
         drive(3, 1000 + i, i, i);
         in_v[3] = (i % 2 == 0);
         step();
         chk("ns1_vld", longint'(o_vld[3]), longint'(i % 2 == 0));
         chk("ns1_rdy", longint'(o_irdy[3]), 1);
      end
      in_v[3] = 1'b0;

      for (int i = 0; i < 4; i++) step();
      for (int k = 0; k < 5; k++) chk($sformatf("final_empty%0d", k), longint'(q[k].size()), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
